param_fetch_pipe: RTL and testbench

- Parametrised successor to the neuron parameter fetch stage. It walks a weight/index table from a programmable base and uses each index plus an offset to fetch the matching input activation.
- Emits one {input value, weight} pair per cycle to the MAC accumulator.
- Adds over the previous generation: start/busy/done handshake, downstream backpressure, programmable table base, and configurable widths.
- Sits between the layer sequencer (which issues start) and the accumulator (which consumes out_* beats).

---
 rtl/param_fetch_pipe.sv | 208 ++++++++++++++++++++
 tb/tb_param_fetch_pipe.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_fetch_pipe.sv
// param_fetch_pipe
//   Walks a weight/index table from a programmable base address. Each index
//   plus an offset forms an input-activation address. The block emits one
//   {input value, weight} beat per cycle to the MAC accumulator, with a
//   start/busy/done handshake and downstream backpressure.
//
//   Memory timing: the weight, index and input memories must present data for
//   a registered address in time to be sampled at the next rising edge. The
//   stage registers below are the only pipeline registers; the memories add
//   no extra register of their own. Under that timing, with o_out_ready held
//   high, the first beat appears in the third cycle after the start cycle, and
//   N beats keep o_busy high for N+2 cycles.
//
//   Build option: define PARAM_FETCH_SKIP_ZERO_EN to drop entries whose weight
//   is zero. No beat is emitted for such an entry, and done still follows the
//   drain of all num_adds entries. Without the macro every entry is emitted.
//
//   state  | meaning
//   -------+-----------------------------------------------------------------
//   IDLE   | waiting for i_start; the table walk is launched on the start edge
//   ISSUE  | issuing consecutive table addresses, one per non-stalled cycle
//   DRAIN  | all addresses issued; waiting for the pipeline to empty
//   DONE   | one-cycle o_done pulse, o_busy low

module param_fetch_pipe #(
   parameter int DW = 16,
   parameter int AW = 16,
   parameter int CW = 16
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_start,
   input  logic [CW-1:0] i_num_adds,
   input  logic [AW-1:0] i_weight_base,
   input  logic [AW-1:0] i_offset,
   output logic          o_busy,
   output logic          o_done,
   output logic [AW-1:0] o_weight_addr,
   input  logic [DW-1:0] i_weight_val,
   output logic [AW-1:0] o_index_addr,
   input  logic [DW-1:0] i_index_val,
   output logic [AW-1:0] o_input_addr,
   input  logic [DW-1:0] i_input_val,
   output logic [DW-1:0] o_out_val,
   output logic [DW-1:0] o_out_weight,
   output logic          o_out_valid,
   input  logic          i_out_ready
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;

   logic          w_launch;
   logic          w_issue;
   logic          w_stall;
   logic          w_keep;
   logic          w_s2_emit;

   logic [CW-1:0] r_remain;
   logic [AW-1:0] r_weight_addr;
   logic [AW-1:0] r_offset;

   logic          r_s1_valid;
   logic          r_s2_valid;
   logic          r_s3_valid;
   logic [DW-1:0] r_weight_reg;
   logic [DW-1:0] r_index_reg;
   logic [DW-1:0] r_out_val;
   logic [DW-1:0] r_out_weight;

   logic [AW-1:0] w_index_aw;

   // A beat is held at the output and the whole pipeline freezes.
   assign w_stall = r_s3_valid & ~i_out_ready;

`ifdef PARAM_FETCH_SKIP_ZERO_EN
   assign w_keep = (r_weight_reg != '0);
`else
   assign w_keep = 1'b1;
`endif

   assign w_s2_emit = r_s2_valid & w_keep;

   generate
      if (DW >= AW) begin : g_idx_trunc
         assign w_index_aw = r_index_reg[AW-1:0];
      end else begin : g_idx_zext
         assign w_index_aw = {{(AW-DW){1'b0}}, r_index_reg};
      end
   endgenerate

   assign o_weight_addr = r_weight_addr;
   assign o_index_addr  = r_weight_addr;
   assign o_input_addr  = w_index_aw + r_offset;
   assign o_out_val     = r_out_val;
   assign o_out_weight  = r_out_weight;
   assign o_out_valid   = r_s3_valid;

   // FSM state register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode, issue strobes and handshake outputs.
   always_comb begin
      w_state_nxt = r_state;
      w_launch    = 1'b0;
      w_issue     = 1'b0;
      o_busy      = 1'b0;
      o_done      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               if (i_num_adds == '0) begin
                  w_state_nxt = S_DONE;
               end else begin
                  w_launch    = 1'b1;
                  w_state_nxt = (i_num_adds == CW'(1)) ? S_DRAIN : S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            o_busy = 1'b1;
            if (!w_stall) begin
               w_issue = 1'b1;
               if (r_remain == CW'(1)) begin
                  w_state_nxt = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            o_busy = 1'b1;
            if (!r_s1_valid && !r_s2_valid && !w_stall) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            o_done      = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Address walk. The first address leaves on the start edge; r_remain
   // counts the addresses still to be issued after that one.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_weight_addr <= '0;
         r_offset      <= '0;
         r_remain      <= '0;
      end else if (w_launch) begin
         r_weight_addr <= i_weight_base;
         r_offset      <= i_offset;
         r_remain      <= i_num_adds - CW'(1);
      end else if (w_issue) begin
         r_weight_addr <= r_weight_addr + AW'(1);
         r_remain      <= r_remain - CW'(1);
      end
   end

   // Stage valid bits; all stages advance together unless the output is stalled.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_s1_valid <= 1'b0;
         r_s2_valid <= 1'b0;
         r_s3_valid <= 1'b0;
      end else if (!w_stall) begin
         r_s1_valid <= w_launch | w_issue;
         r_s2_valid <= r_s1_valid;
         r_s3_valid <= w_s2_emit;
      end
   end

   // Stage data registers. Data is captured only for live entries, so the
   // output holds its last beat when bubbles pass through.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_weight_reg <= '0;
         r_index_reg  <= '0;
         r_out_val    <= '0;
         r_out_weight <= '0;
      end else if (!w_stall) begin
         if (r_s1_valid) begin
            r_weight_reg <= i_weight_val;
            r_index_reg  <= i_index_val;
         end
         if (w_s2_emit) begin
            r_out_val    <= i_input_val;
            r_out_weight <= r_weight_reg;
         end
      end
   end

endmodule

// File: tb/tb_param_fetch_pipe.sv
// Directed bench for param_fetch_pipe. The weight and index memories are
// flow-through arrays read at the registered address. The input memory returns
// its own address, so input[a] = a.
module tb_param_fetch_pipe;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] num_adds;
   logic [15:0] weight_base;
   logic [15:0] offset;
   logic        busy;
   logic        done;
   logic [15:0] weight_addr;
   logic [15:0] weight_val;
   logic [15:0] index_addr;
   logic [15:0] index_val;
   logic [15:0] input_addr;
   logic [15:0] input_val;
   logic [15:0] out_val;
   logic [15:0] out_weight;
   logic        out_valid;
   logic        out_ready;

   logic [15:0] wmem [0:65535];
   logic [15:0] xmem [0:65535];

   int tests = 0;
   int fails = 0;

   assign weight_val = wmem[weight_addr];
   assign index_val  = xmem[index_addr];
   assign input_val  = input_addr;

   param_fetch_pipe #(.DW(16), .AW(16), .CW(16)) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_start       (start),
      .i_num_adds    (num_adds),
      .i_weight_base (weight_base),
      .i_offset      (offset),
      .o_busy        (busy),
      .o_done        (done),
      .o_weight_addr (weight_addr),
      .i_weight_val  (weight_val),
      .o_index_addr  (index_addr),
      .i_index_val   (index_val),
      .o_input_addr  (input_addr),
      .i_input_val   (input_val),
      .o_out_val     (out_val),
      .o_out_weight  (out_weight),
      .o_out_valid   (out_valid),
      .i_out_ready   (out_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // Pulses start for one edge; returns at the sample point of the cycle after it.
   task automatic launch(input logic [15:0] n, input logic [15:0] base, input logic [15:0] off);
      num_adds    = n;
      weight_base = base;
      offset      = off;
      start       = 1'b1;
      step();
      start       = 1'b0;
   endtask

   task automatic check_beat(input string tag, input logic [15:0] v, input logic [15:0] w);
      check({tag, ".valid"},  {31'd0, out_valid}, 32'd1);
      check({tag, ".val"},    {16'd0, out_val},   {16'd0, v});
      check({tag, ".weight"}, {16'd0, out_weight}, {16'd0, w});
   endtask

   task automatic load_stream(input int n);
      for (int i = 0; i < n; i++) begin
         wmem[16'h0010 + i] = 16'(i + 1);
         xmem[16'h0010 + i] = 16'(2 * i);
      end
   endtask

   initial begin
      int          beats;
      logic [15:0] first_w;
      logic [15:0] last_w;
      logic [15:0] first_v;
      logic        seen;

      rst         = 1'b0;
      start       = 1'b0;
      num_adds    = '0;
      weight_base = '0;
      offset      = '0;
      out_ready   = 1'b1;
      for (int a = 0; a < 65536; a++) begin
         wmem[a] = '0;
         xmem[a] = '0;
      end
      #1 rst = 1'b1;

      // Reset: outputs cleared even with start asserted
      start    = 1'b1;
      num_adds = 16'd4;
      step();
      check("rst.busy",        {31'd0, busy},      32'd0);
      check("rst.done",        {31'd0, done},      32'd0);
      check("rst.out_valid",   {31'd0, out_valid}, 32'd0);
      check("rst.out_val",     {16'd0, out_val},   32'd0);
      check("rst.out_weight",  {16'd0, out_weight}, 32'd0);
      check("rst.weight_addr", {16'd0, weight_addr}, 32'd0);
      check("rst.index_addr",  {16'd0, index_addr}, 32'd0);
      start = 1'b0;
      step();
      rst = 1'b0;
      step();

      // Basic stream: 4 beats, base 0x10, offset 0x100
      load_stream(4);
      launch(16'd4, 16'h0010, 16'h0100);
      check("a.c1.busy",        {31'd0, busy},        32'd1);
      check("a.c1.weight_addr", {16'd0, weight_addr}, 32'h10);
      check("a.c1.index_addr",  {16'd0, index_addr},  32'h10);
      check("a.c1.out_valid",   {31'd0, out_valid},   32'd0);
      step();
      check("a.c2.out_valid",   {31'd0, out_valid},   32'd0);
      check("a.c2.weight_addr", {16'd0, weight_addr}, 32'h11);
      check("a.c2.input_addr",  {16'd0, input_addr},  32'h100);
      step();
      check_beat("a.b1", 16'h0100, 16'd1);
      step();
      check_beat("a.b2", 16'h0102, 16'd2);
      step();
      check_beat("a.b3", 16'h0104, 16'd3);
      step();
      check_beat("a.b4", 16'h0106, 16'd4);
      check("a.c6.busy", {31'd0, busy}, 32'd1);
      check("a.c6.done", {31'd0, done}, 32'd0);
      step();
      check("a.c7.done",      {31'd0, done},      32'd1);
      check("a.c7.busy",      {31'd0, busy},      32'd0);
      check("a.c7.out_valid", {31'd0, out_valid}, 32'd0);
      step();
      check("a.c8.done", {31'd0, done}, 32'd0);

      // Zero count: immediate done, no beats, address untouched
      launch(16'd0, 16'h0055, 16'h0000);
      check("z.done",        {31'd0, done},        32'd1);
      check("z.busy",        {31'd0, busy},        32'd0);
      check("z.out_valid",   {31'd0, out_valid},   32'd0);
      check("z.weight_addr", {16'd0, weight_addr}, 32'h13);
      step();
      check("z.done_low",  {31'd0, done},      32'd0);
      check("z.out_valid2", {31'd0, out_valid}, 32'd0);

      // Backpressure: beat 2 stalled for 3 cycles
      launch(16'd4, 16'h0010, 16'h0100);
      step();
      step();
      check_beat("bp.b1", 16'h0100, 16'd1);
      step();
      check_beat("bp.b2", 16'h0102, 16'd2);
      out_ready = 1'b0;
      step();
      check_beat("bp.hold1", 16'h0102, 16'd2);
      check("bp.hold1.busy", {31'd0, busy}, 32'd1);
      step();
      check_beat("bp.hold2", 16'h0102, 16'd2);
      check("bp.hold2.weight_addr", {16'd0, weight_addr}, 32'h13);
      step();
      check_beat("bp.hold3", 16'h0102, 16'd2);
      check("bp.hold3.done", {31'd0, done}, 32'd0);
      out_ready = 1'b1;
      step();
      check_beat("bp.b3", 16'h0104, 16'd3);
      step();
      check_beat("bp.b4", 16'h0106, 16'd4);
      check("bp.c9.done", {31'd0, done}, 32'd0);
      step();
      check("bp.c10.done",      {31'd0, done},      32'd1);
      check("bp.c10.out_valid", {31'd0, out_valid}, 32'd0);
      step();

      // Address wrap
      wmem[16'hFFFE] = 16'd9;
      wmem[16'hFFFF] = 16'd8;
      wmem[16'h0000] = 16'd7;
      xmem[16'hFFFE] = 16'hFFF0;
      xmem[16'hFFFF] = 16'h0001;
      xmem[16'h0000] = 16'h0002;
      launch(16'd3, 16'hFFFE, 16'h0020);
      check("w.c1.weight_addr", {16'd0, weight_addr}, 32'hFFFE);
      step();
      check("w.c2.weight_addr", {16'd0, weight_addr}, 32'hFFFF);
      check("w.c2.input_addr",  {16'd0, input_addr},  32'h0010);
      step();
      check("w.c3.weight_addr", {16'd0, weight_addr}, 32'h0000);
      check_beat("w.b1", 16'h0010, 16'd9);
      step();
      check_beat("w.b2", 16'h0021, 16'd8);
      step();
      check_beat("w.b3", 16'h0022, 16'd7);
      step();
      check("w.done", {31'd0, done}, 32'd1);
      step();

      // Reset mid-operation, then a clean 2-beat run
      load_stream(8);
      launch(16'd8, 16'h0010, 16'h0100);
      step();
      step();
      check_beat("r.b1", 16'h0100, 16'd1);
      step();
      check_beat("r.b2", 16'h0102, 16'd2);
      #2 rst = 1'b1;
      #1;
      check("r.async.out_valid",   {31'd0, out_valid},   32'd0);
      check("r.async.busy",        {31'd0, busy},        32'd0);
      check("r.async.done",        {31'd0, done},        32'd0);
      check("r.async.out_val",     {16'd0, out_val},     32'd0);
      check("r.async.out_weight",  {16'd0, out_weight},  32'd0);
      check("r.async.weight_addr", {16'd0, weight_addr}, 32'd0);
      step();
      rst  = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         if (done || out_valid || busy) seen = 1'b1;
      end
      check("r.quiet_after_reset", {31'd0, seen}, 32'd0);
      launch(16'd2, 16'h0010, 16'h0100);
      check("r2.c1.busy", {31'd0, busy}, 32'd1);
      step();
      step();
      check_beat("r2.b1", 16'h0100, 16'd1);
      step();
      check_beat("r2.b2", 16'h0102, 16'd2);
      step();
      check("r2.done",      {31'd0, done},      32'd1);
      check("r2.out_valid", {31'd0, out_valid}, 32'd0);
      step();

      // Zero-weight entries {5,0,0,7}
      wmem[16'h0040] = 16'd5;
      wmem[16'h0041] = 16'd0;
      wmem[16'h0042] = 16'd0;
      wmem[16'h0043] = 16'd7;
      for (int i = 0; i < 4; i++) xmem[16'h0040 + i] = 16'(i);
      launch(16'd4, 16'h0040, 16'h0000);
      beats   = 0;
      first_w = 16'hDEAD;
      first_v = 16'hDEAD;
      last_w  = 16'hDEAD;
      for (int k = 0; k < 6; k++) begin
         if (out_valid) begin
            if (beats == 0) begin
               first_w = out_weight;
               first_v = out_val;
            end
            last_w = out_weight;
            beats++;
         end
         step();
      end
`ifdef PARAM_FETCH_SKIP_ZERO_EN
      check("sz.beats", beats, 32'd2);
`else
      check("sz.beats", beats, 32'd4);
`endif
      check("sz.first_weight", {16'd0, first_w}, 32'd5);
      check("sz.first_val",    {16'd0, first_v}, 32'd0);
      check("sz.last_weight",  {16'd0, last_w},  32'd7);
      check("sz.done",         {31'd0, done},    32'd1);
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
